// File: rtl/my_alu_pipe_if.sv
// Operand/control bundle in, result bundle out, each with its own valid/ready pair.
// The ovf wire exists only when MY_ALU_PIPE_OVF_EN is defined.
interface my_alu_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        zx, nx, zy, ny, f, no;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr;
    logic        ng;
`ifdef MY_ALU_PIPE_OVF_EN
    logic        ovf;
`endif

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        input  in_ready, out_valid, out, zr, ng
`ifdef MY_ALU_PIPE_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        output in_ready, out_valid, out, zr, ng
`ifdef MY_ALU_PIPE_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/my_alu_pipe.sv
// Two-stage pipelined 16-bit Hack ALU; MY_ALU_PIPE_OVF_EN adds a registered signed-add ovf flag.
// Latency: 2 cycles from input transfer to out_valid; 1 bundle per cycle sustained.
// Backpressure: S2 holds while out_ready is low; in_ready drops only when both stages are full.
module my_alu_pipe (
    input  logic         clk,
    input  logic         rst_n,
    my_alu_pipe_if.slave bus
);
    logic        v1_q, v1_d, v2_q, v2_d;
    logic [15:0] xp_q, xp_d, yp_q, yp_d;
    logic        f_q, f_d, no_q, no_d;
    logic [15:0] out_q, out_d;
    logic        zr_q, zr_d, ng_q, ng_d;
    logic        s2_ready, in_fire, s1_adv, out_fire;
    logic [15:0] x_z, y_z, r, res;
`ifdef MY_ALU_PIPE_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    assign s2_ready     = ~v2_q | bus.out_ready;
    assign bus.in_ready = ~v1_q | s2_ready;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign s1_adv       = v1_q & s2_ready;
    assign out_fire     = v2_q & bus.out_ready;

    assign x_z = bus.zx ? 16'h0000 : bus.x;
    assign y_z = bus.zy ? 16'h0000 : bus.y;
    assign r   = f_q ? (xp_q + yp_q) : (xp_q & yp_q);
    assign res = no_q ? ~r : r;

    always_comb begin
        v1_d  = v1_q;
        v2_d  = v2_q;
        xp_d  = xp_q;
        yp_d  = yp_q;
        f_d   = f_q;
        no_d  = no_q;
        out_d = out_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
`ifdef MY_ALU_PIPE_OVF_EN
        ovf_d = ovf_q;
`endif
        // S1 empties when it advances; a same-cycle input refills it.
        if (s1_adv)   v1_d = 1'b0;
        if (in_fire)  v1_d = 1'b1;
        if (out_fire) v2_d = 1'b0;
        if (s1_adv)   v2_d = 1'b1;

        if (in_fire) begin
            xp_d = bus.nx ? ~x_z : x_z;
            yp_d = bus.ny ? ~y_z : y_z;
            f_d  = bus.f;
            no_d = bus.no;
        end
        if (s1_adv) begin
            out_d = res;
            zr_d  = ~|res;
            ng_d  = res[15];
`ifdef MY_ALU_PIPE_OVF_EN
            // Overflow of the sum before output negation.
            ovf_d = f_q & (xp_q[15] == yp_q[15]) & (r[15] != xp_q[15]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            xp_q  <= 16'h0000;
            yp_q  <= 16'h0000;
            f_q   <= 1'b0;
            no_q  <= 1'b0;
            out_q <= 16'h0000;
            zr_q  <= 1'b1;
            ng_q  <= 1'b0;
`ifdef MY_ALU_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            xp_q  <= xp_d;
            yp_q  <= yp_d;
            f_q   <= f_d;
            no_q  <= no_d;
            out_q <= out_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
`ifdef MY_ALU_PIPE_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
`ifdef MY_ALU_PIPE_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_my_alu_pipe.sv
// Self-checking bench for my_alu_pipe: table vectors, hand sequences and a random stream vs a queue model.
module tb_my_alu_pipe;
    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctl;
        exp_t        e;
    } in_t;

    typedef struct {
        exp_t e;
        int   acc;
    } sb_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctl;
        logic [15:0] eout;
        logic        ezr;
        logic        eng;
        logic        eovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    my_alu_pipe_if bus ();
    my_alu_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    logic ordy = 1'b1;
    logic hold_pend = 1'b0;
    exp_t held;
    in_t  feed_q[$];
    sb_t  sb[$];
    vec_t tbl[9];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: operands as unsigned integers, overflow judged on signed values.
    function automatic exp_t ref_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
        int unsigned xv, yv, rv;
        int sx, sy;
        exp_t e;
        xv = c[5] ? 0 : 32'(x);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : 32'(y);
        if (c[2]) yv = 65535 - yv;
        rv = c[1] ? (xv + yv) % 65536 : (xv & yv);
        sx = (xv >= 32768) ? int'(xv) - 65536 : int'(xv);
        sy = (yv >= 32768) ? int'(yv) - 65536 : int'(yv);
        e.ovf = c[1] && ((sx + sy) > 32767 || (sx + sy) < -32768);
        if (c[0]) rv = 65535 - rv;
        e.out = rv[15:0];
        e.zr  = (rv == 0);
        e.ng  = (rv >= 32768);
        return e;
    endfunction

    task automatic push_in(logic [15:0] x, logic [15:0] y, logic [5:0] c, exp_t e);
        in_t t;
        t.x = x; t.y = y; t.ctl = c; t.e = e;
        feed_q.push_back(t);
    endtask

    // Called at a negedge: drive, check against the model, then advance one clock.
    task automatic step();
        in_t  h;
        sb_t  s;
        exp_t cur;
        logic exp_vld;
        if (feed_q.size() > 0) begin
            h = feed_q[0];
            bus.in_valid = 1'b1;
            bus.x = h.x;
            bus.y = h.y;
            {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = h.ctl;
        end else begin
            bus.in_valid = 1'b0;
            bus.x = 16'($urandom);
            bus.y = 16'($urandom);
            {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'($urandom);
        end
        bus.out_ready = ordy;
        #1;
        cur.out = bus.out; cur.zr = bus.zr; cur.ng = bus.ng; cur.ovf = 1'b0;
`ifdef MY_ALU_PIPE_OVF_EN
        cur.ovf = bus.ovf;
`endif
        if (hold_pend) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_out", bus.out, held.out);
            chk("hold_zr", bus.zr, held.zr);
            chk("hold_ng", bus.ng, held.ng);
`ifdef MY_ALU_PIPE_OVF_EN
            chk("hold_ovf", bus.ovf, held.ovf);
`endif
        end
        exp_vld = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
        chk("out_valid", bus.out_valid, exp_vld);
        chk("in_ready", bus.in_ready, (sb.size() < 2) || ordy);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", bus.out_valid, 0);
            end else begin
                s = sb.pop_front();
                chk("out", bus.out, s.e.out);
                chk("zr", bus.zr, s.e.zr);
                chk("ng", bus.ng, s.e.ng);
`ifdef MY_ALU_PIPE_OVF_EN
                chk("ovf", bus.ovf, s.e.ovf);
`endif
                n_out++;
            end
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        held = cur;
        if (bus.in_valid && bus.in_ready) begin
            s.e = h.e;
            s.acc = cyc;
            sb.push_back(s);
            void'(feed_q.pop_front());
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(string name);
        int n = 0;
        ordy = 1'b1;
        while ((feed_q.size() > 0 || sb.size() > 0) && n < 60) begin
            step();
            n++;
        end
        chk(name, feed_q.size() + sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        feed_q.delete();
        sb.delete();
        hold_pend = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out", bus.out, 0);
        chk("rst_zr", bus.zr, 1);
        chk("rst_ng", bus.ng, 0);
`ifdef MY_ALU_PIPE_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   acc0;
        logic [15:0] rx, ry;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.x = 16'h0; bus.y = 16'h0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b0;

        tbl[0] = '{16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0003, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'h0005, 16'h0003, 6'b001101, 16'hFFFA, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0003, 6'b000111, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'h0005, 16'h0003, 6'b000000, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0003, 6'b010101, 16'h0007, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1, 1'b1};

        #2;
        do_reset();
        ordy = 1'b1;
        repeat (2) step();

        // Table vectors streamed back-to-back with the sink always ready.
        for (int i = 0; i < 9; i++) begin
            e.out = tbl[i].eout; e.zr = tbl[i].ezr; e.ng = tbl[i].eng; e.ovf = tbl[i].eovf;
            push_in(tbl[i].x, tbl[i].y, tbl[i].ctl, e);
        end
        drain("table_drain");

        // Backpressure: 4 bundles, sink stalled for 5 cycles.
        acc0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            rx = 16'(i * 7 + 1); ry = 16'(i + 2);
            push_in(rx, ry, 6'b000010, ref_alu(rx, ry, 6'b000010));
        end
        ordy = 1'b0;
        repeat (5) step();
        chk("bp_accepts", n_acc - acc0, 2);
        acc0 = n_out;
        drain("bp_drain");
        chk("bp_outputs", n_out - acc0, 4);

        // Simultaneous drain/fill with out_ready cycling 1,0,1,1.
        for (int i = 0; i < 16; i++) begin
            rx = 16'($urandom); ry = 16'($urandom);
            push_in(rx, ry, 6'b010011, ref_alu(rx, ry, 6'b010011));
        end
        for (int i = 0; i < 16; i++) begin
            ordy = (i % 4 != 1);
            step();
        end
        drain("toggle_drain");

        // Reset while both stages are full; no stale result afterwards.
        for (int i = 0; i < 3; i++) push_in(16'h1234, 16'h0F0F, 6'b000010, ref_alu(16'h1234, 16'h0F0F, 6'b000010));
        ordy = 1'b0;
        repeat (3) step();
        chk("pre_rst_full", bus.in_ready, 0);
        do_reset();
        ordy = 1'b1;
        repeat (4) step();

        // Random stream with random backpressure.
        for (int i = 0; i < 400; i++) begin
            ordy = ($urandom_range(0, 3) != 0);
            if (feed_q.size() < 2 && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0: rx = 16'h7FFF;
                    1: rx = 16'h8000;
                    2: rx = 16'hFFFF;
                    default: rx = 16'($urandom);
                endcase
                ry = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
                acc0 = 32'($urandom_range(0, 63));
                push_in(rx, ry, acc0[5:0], ref_alu(rx, ry, acc0[5:0]));
            end
            step();
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
